// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC generation, req/ack instruction fetch, 1-entry skid buffer
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic        r_skid_full;
  logic        r_kill;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic        w_consume;
  logic        w_slot_free;
  logic        w_ack;

  assign w_target    = redirect_pc_i & ~32'd3;
  assign w_pc_next   = r_pc_q + 32'd4;
  assign w_consume   = r_valid & ~stall_i;
  assign w_slot_free = ~r_valid | w_consume;
  // Acks are only meaningful while a request is actually being presented.
  assign w_ack       = imem_ack_i & (r_state == S_REQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_BOOT;
      r_pc_q      <= RESET_PC;
      r_addr_q    <= 32'd0;
      r_skid_inst <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_full <= 1'b0;
      r_kill      <= 1'b0;
      r_inst      <= 32'd0;
      r_pc        <= 32'd0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_REQ;
          if (redirect_i) begin
            r_pc_q   <= w_target;
            r_addr_q <= w_target;
          end else begin
            r_addr_q <= r_pc_q;
          end
        end
        S_REQ: begin
          if (redirect_i) begin
            r_pc_q      <= w_target;
            r_valid     <= 1'b0;
            r_inst      <= 32'd0;
            r_skid_full <= 1'b0;
            // Without an ack the old address must stay on the bus; its data is killed later.
            if (w_ack) begin
              r_addr_q <= w_target;
              r_kill   <= 1'b0;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (w_ack && r_kill) begin
            r_kill   <= 1'b0;
            r_addr_q <= r_pc_q;
            if (w_consume) r_valid <= 1'b0;
          end else if (w_ack) begin
            r_pc_q <= w_pc_next;
            if (w_slot_free) begin
              r_inst   <= imem_rdata_i;
              r_pc     <= r_addr_q;
              r_valid  <= 1'b1;
              r_addr_q <= w_pc_next;
            end else begin
              r_skid_inst <= imem_rdata_i;
              r_skid_pc   <= r_addr_q;
              r_skid_full <= 1'b1;
              r_state     <= S_FULL;
            end
          end else if (w_consume) begin
            r_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (redirect_i) begin
            r_pc_q      <= w_target;
            r_addr_q    <= w_target;
            r_valid     <= 1'b0;
            r_inst      <= 32'd0;
            r_skid_full <= 1'b0;
            r_state     <= S_REQ;
          end else if (w_consume) begin
            r_inst      <= r_skid_inst;
            r_pc        <= r_skid_pc;
            r_skid_full <= 1'b0;
            r_addr_q    <= r_pc_q;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign imem_req_o  = (r_state == S_REQ);
  assign imem_addr_o = r_addr_q;
  assign inst_o      = r_inst;
  assign pc_o        = r_pc;
  assign valid_o     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : self-checking bench, memory model plus in-order stream model
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int tests = 0;
  int fails = 0;

  // Memory model state
  int          cur_lat = 1;
  int          wcnt = 0;
  bit          rand_lat = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  // Drives one cycle of inputs; memory acks after cur_lat cycles of req, data = addr ^ MAGIC.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic junk);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (imem_req_o) begin
      if (wcnt >= cur_lat - 1) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = imem_addr_o ^ MAGIC;
      end else begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
      end
    end else begin
      imem_ack_i   = junk;
      imem_rdata_i = $urandom;
    end
    prev_req  = imem_req_o;
    prev_ack  = imem_ack_i;
    prev_addr = imem_addr_o;
    if (imem_req_o && imem_ack_i) begin
      wcnt = 0;
      if (rand_lat) cur_lat = $urandom_range(1, 4);
    end else if (imem_req_o) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the DUT in its first REQ cycle at RESET_PC.
  task automatic apply_reset();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    tests++; if (inst_o !== 32'd0) begin fails++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
    tests++; if (pc_o !== 32'd0) begin fails++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    tests++; if (imem_addr_o !== 32'd0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
    rst_i = 1'b0;
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL boot_bubble req=%b exp=0", imem_req_o); end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0) begin
      fails++; $display("FAIL first_req req=%b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    cur_lat = 1; rand_lat = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        e = 32'(4 * i);
        tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== e) begin
          fails++; $display("FAIL zw_req cyc=%0d req=%b addr=%h exp req=1 addr=%h", i, imem_req_o, imem_addr_o, e);
        end
      end
      if (i == 0) begin
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL zw_valid0 got=%b exp=0", valid_o); end
      end else begin
        e = 32'(4 * (i - 1));
        tests++;
        if (valid_o !== 1'b1 || pc_o !== e || inst_o !== (e ^ MAGIC)) begin
          fails++; $display("FAIL zw_out cyc=%0d v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, valid_o, pc_o, inst_o, e, e ^ MAGIC);
        end
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
    end
  endtask

  task automatic test_latency();
    logic [31:0] ea;
    logic [31:0] ep;
    logic        ev;
    cur_lat = 3; rand_lat = 1'b0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      ea = 32'(4 * (c / 3));
      ev = (c >= 3) && (c % 3 == 0);
      ep = 32'(4 * (c / 3 - 1));
      tests++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== ea) begin
        fails++; $display("FAIL lat_req cyc=%0d req=%b addr=%h exp req=1 addr=%h", c, imem_req_o, imem_addr_o, ea);
      end
      tests++;
      if (valid_o !== ev || (ev && (pc_o !== ep || inst_o !== (ep ^ MAGIC)))) begin
        fails++; $display("FAIL lat_out cyc=%0d v=%b pc=%h inst=%h exp v=%b pc=%h", c, valid_o, pc_o, inst_o, ev, ep);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    logic        st;
    cur_lat = 1; rand_lat = 1'b0;
    apply_reset();
    exp_pc = 32'd0;
    for (int c = 0; c < 12; c++) begin
      st = (c >= 2 && c <= 5);
      if (c >= 3 && c <= 5) begin
        tests++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h4 || inst_o !== (32'h4 ^ MAGIC)) begin
          fails++; $display("FAIL stall_hold cyc=%0d req=%b v=%b pc=%h exp req=0 v=1 pc=4", c, imem_req_o, valid_o, pc_o);
        end
      end
      if (valid_o && !st) begin
        tests++;
        if (pc_o !== exp_pc || inst_o !== (exp_pc ^ MAGIC)) begin
          fails++; $display("FAIL stall_stream pc=%h inst=%h exp pc=%h inst=%h", pc_o, inst_o, exp_pc, exp_pc ^ MAGIC);
        end
        exp_pc += 32'd4;
      end
      drive(st, 1'b0, 32'd0, 1'b0);
    end
    tests++;
    if (exp_pc !== 32'h1C) begin fails++; $display("FAIL stall_count next_pc=%h exp=0000001c", exp_pc); end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] exp_pc;
    logic        rd;
    cur_lat = 3; rand_lat = 1'b0;
    apply_reset();
    exp_pc = 32'd0;
    for (int c = 0; c < 15; c++) begin
      rd = (c == 7);
      if (c == 8) begin
        tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || valid_o !== 1'b0) begin
          fails++; $display("FAIL redir_hold req=%b addr=%h v=%b exp req=1 addr=8 v=0", imem_req_o, imem_addr_o, valid_o);
        end
      end
      if (c == 9) begin
        tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
          fails++; $display("FAIL redir_target req=%b addr=%h exp req=1 addr=100", imem_req_o, imem_addr_o);
        end
      end
      if (c == 12) begin
        tests++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100) begin
          fails++; $display("FAIL redir_first v=%b pc=%h exp v=1 pc=100", valid_o, pc_o);
        end
      end
      if (valid_o && !rd) begin
        tests++;
        if (pc_o !== exp_pc || inst_o !== (exp_pc ^ MAGIC)) begin
          fails++; $display("FAIL redir_stream pc=%h inst=%h exp pc=%h", pc_o, inst_o, exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (rd) exp_pc = 32'h100;
      drive(1'b0, rd, 32'h100, 1'b0);
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] exp_pc;
    logic        st;
    logic        rd;
    cur_lat = 1; rand_lat = 1'b0;
    apply_reset();
    exp_pc = 32'd0;
    for (int c = 0; c < 10; c++) begin
      st = (c == 2 || c == 3);
      rd = (c == 3);
      if (c == 3) begin
        tests++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h4) begin
          fails++; $display("FAIL full_state req=%b v=%b pc=%h exp req=0 v=1 pc=4", imem_req_o, valid_o, pc_o);
        end
      end
      if (c == 4) begin
        tests++;
        if (valid_o !== 1'b0 || inst_o !== 32'd0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
          fails++; $display("FAIL full_flush v=%b inst=%h req=%b addr=%h exp v=0 inst=0 req=1 addr=200", valid_o, inst_o, imem_req_o, imem_addr_o);
        end
      end
      if (valid_o && !st && !rd) begin
        tests++;
        if (pc_o !== exp_pc || inst_o !== (exp_pc ^ MAGIC)) begin
          fails++; $display("FAIL full_stream pc=%h inst=%h exp pc=%h", pc_o, inst_o, exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (rd) exp_pc = 32'h203 & ~32'd3;
      drive(st, rd, 32'h203, 1'b0);
    end
    tests++;
    if (exp_pc !== 32'h214) begin fails++; $display("FAIL full_count next_pc=%h exp=00000214", exp_pc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_pc;
    cur_lat = 3; rand_lat = 1'b0;
    apply_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    tests++;
    if ({inst_o, pc_o, valid_o, imem_req_o, imem_addr_o} !== 98'd0) begin
      fails++; $display("FAIL midrst_outs inst=%h pc=%h v=%b req=%b addr=%h exp all 0", inst_o, pc_o, valid_o, imem_req_o, imem_addr_o);
    end
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    exp_pc = 32'd0;
    for (int c = 0; c < 8; c++) begin
      if (valid_o) begin
        tests++;
        if (pc_o !== exp_pc || inst_o !== (exp_pc ^ MAGIC)) begin
          fails++; $display("FAIL midrst_stream pc=%h inst=%h exp pc=%h", pc_o, inst_o, exp_pc);
        end
        exp_pc += 32'd4;
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
    end
    tests++;
    if (exp_pc !== 32'h8) begin fails++; $display("FAIL midrst_count next_pc=%h exp=00000008", exp_pc); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    logic        st;
    logic        rd;
    logic        junk;
    logic        redir_prev;
    int          consumed;
    cur_lat = $urandom_range(1, 4); rand_lat = 1'b1;
    apply_reset();
    exp_pc     = 32'd0;
    redir_prev = 1'b0;
    consumed   = 0;
    for (int c = 0; c < 3000; c++) begin
      st   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 29) == 0);
      rpc  = $urandom;
      junk = $urandom_range(0, 1) == 1;
      if (prev_req && !prev_ack) begin
        tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
          fails++; $display("FAIL rnd_req_stable cyc=%0d req=%b addr=%h exp req=1 addr=%h", c, imem_req_o, imem_addr_o, prev_addr);
        end
      end
      if (redir_prev) begin
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL rnd_flush cyc=%0d v=%b exp=0", c, valid_o); end
      end
      if (valid_o && !st && !rd) begin
        tests++;
        if (pc_o !== exp_pc || inst_o !== (exp_pc ^ MAGIC)) begin
          fails++; $display("FAIL rnd_stream cyc=%0d pc=%h inst=%h exp pc=%h inst=%h", c, pc_o, inst_o, exp_pc, exp_pc ^ MAGIC);
        end
        exp_pc += 32'd4;
        consumed++;
      end
      if (rd) exp_pc = rpc & ~32'd3;
      redir_prev = rd;
      drive(st, rd, rpc, junk);
    end
    tests++;
    if (consumed < 300) begin fails++; $display("FAIL rnd_progress consumed=%0d exp>=300", consumed); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_inflight();
    test_redirect_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
